// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RV32I core.
//
// Produces stall and flush strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. It handles load-use hazards, taken branches and jumps, and
// multi-cycle instruction-fetch and data-memory waits. After a redirect it
// tracks a stale fetch that is still in flight, and it runs a watchdog on
// data-memory busy periods.
//
// Optional feature macro: HAZARD_PERF_EN
//   defined   : StallCnt and FlushCnt count the cycles with StallF=1 and FlushD=1.
//   undefined : StallCnt and FlushCnt are tied to 0 and no counter flops exist.
//
// Ports:
//   clk, rst          core clock; asynchronous active-high reset
//   Rs1D, Rs2D        source registers of the instruction in D
//   IFID_valid        D holds a real instruction
//   RdE, LoadE        destination register in E, and whether E holds a load
//   PCSrcE            taken branch or jump resolved in E
//   ImemReadyF        instruction memory returns InstrF this cycle
//   DmemBusyM         data memory not done; M must hold
//   StallF/StallD/FlushD/StallE/FlushE/StallM/FlushW   pipeline strobes
//   BusErr            sticky data-memory watchdog error
//   StallCnt/FlushCnt performance counters (0 unless HAZARD_PERF_EN)
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TW          = $clog2(MEM_TIMEOUT + 1),
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic              IFID_valid,
  input  logic [4:0]        RdE,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              ImemReadyF,
  input  logic              DmemBusyM,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              StallE,
  output logic              FlushE,
  output logic              StallM,
  output logic              FlushW,
  output logic              BusErr,
  output logic [PERF_W-1:0] StallCnt,
  output logic [PERF_W-1:0] FlushCnt
);

  typedef enum logic [1:0] {RUN, DROP, MEM_WAIT} state_t;

  localparam logic [TW:0]   TIMEOUT_W = (TW+1)'(MEM_TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_Q = TW'(MEM_TIMEOUT);

  state_t        state_q, state_d, eff_state;
  logic          drop_q, drop_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [TW:0]   wd_inc;
  logic          buserr_q, buserr_d;
  logic          err_now;
  logic          lw_stall;
  logic          stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      drop_q   <= 1'b0;
      wd_q     <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      wd_q     <= wd_d;
      buserr_q <= buserr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    wd_d     = wd_q;
    buserr_d = buserr_q;
    err_now  = 1'b0;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    stall_e  = 1'b0;
    flush_e  = 1'b0;
    stall_m  = 1'b0;
    flush_w  = 1'b0;

    lw_stall = LoadE & (RdE != 5'd0) & IFID_valid & ((RdE == Rs1D) | (RdE == Rs2D));
    wd_inc   = {1'b0, wd_q} + {{TW{1'b0}}, 1'b1};

    // The cycle busy drops is handled as if already in the state being returned to.
    eff_state = state_q;
    if (state_q == MEM_WAIT) eff_state = drop_q ? DROP : RUN;

    if (DmemBusyM) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
      // The watchdog counts every busy cycle, including the one that enters
      // MEM_WAIT, so the error shows in the cycle the count reaches the limit.
      err_now  = (wd_inc >= TIMEOUT_W);
      buserr_d = buserr_q | err_now;
      wd_d     = err_now ? TIMEOUT_Q : wd_inc[TW-1:0];
      if (state_q != MEM_WAIT) begin
        drop_d  = (state_q == DROP);
        state_d = MEM_WAIT;
      end
    end else begin
      wd_d   = '0;
      drop_d = 1'b0;
      case (eff_state)
        RUN: begin
          state_d = RUN;
          if (PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            // The wrong-path fetch is still outstanding and must be discarded.
            if (!ImemReadyF) state_d = DROP;
          end else if (lw_stall) begin
            // StallD wins over the fetch bubble, even while fetch is waiting.
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else if (!ImemReadyF) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
          end
        end
        DROP: begin
          stall_f = 1'b1;
          flush_d = 1'b1;
          if (PCSrcE) flush_e = 1'b1;
          if (lw_stall) begin
            stall_d = 1'b1;
            flush_e = 1'b1;
            flush_d = 1'b0;
          end
          if (PCSrcE)          state_d = DROP;
          else if (ImemReadyF) state_d = RUN;
          else                 state_d = DROP;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign StallF = ~rst & stall_f;
  assign StallD = ~rst & stall_d;
  assign FlushD = ~rst & flush_d;
  assign StallE = ~rst & stall_e;
  assign FlushE = ~rst & flush_e;
  assign StallM = ~rst & stall_m;
  assign FlushW = ~rst & flush_w;
  assign BusErr = ~rst & (buserr_q | err_now);

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (FlushD) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MT = 8;
  localparam int PW = 32;

  // Strobe vector order: {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW}
  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_LW    = 7'b1100100;
  localparam logic [6:0] S_REDIR = 7'b0010100;
  localparam logic [6:0] S_FWAIT = 7'b1010000;
  localparam logic [6:0] S_BUSY  = 7'b1101011;
  localparam logic [6:0] S_DRPBR = 7'b1010100;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic IFID_valid, LoadE, PCSrcE, ImemReadyF, DmemBusyM;
  logic StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, BusErr;
  logic [PW-1:0] StallCnt, FlushCnt;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .IFID_valid(IFID_valid), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .ImemReadyF(ImemReadyF), .DmemBusyM(DmemBusyM),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .StallE(StallE),
    .FlushE(FlushE), .StallM(StallM), .FlushW(FlushW), .BusErr(BusErr),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       v;
    logic [4:0] rd;
    logic       ld;
    logic       pc;
    logic       im;
    logic       busy;
    logic [6:0] s;
    logic       e;
  } vec_t;

  typedef struct packed {
    logic [6:0] s;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[28];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic v, logic [4:0] rd,
                              logic ld, logic pc, logic im, logic busy,
                              logic [6:0] s, logic e);
    vec_t t;
    t.rs1 = rs1; t.rs2 = rs2; t.v = v; t.rd = rd; t.ld = ld;
    t.pc = pc; t.im = im; t.busy = busy; t.s = s; t.e = e;
    return t;
  endfunction

  function automatic vec_t idle(logic [6:0] s, logic e);
    return mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, s, e);
  endfunction

  function automatic logic [6:0] strobes();
    return {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    Rs1D = t.rs1; Rs2D = t.rs2; IFID_valid = t.v; RdE = t.rd;
    LoadE = t.ld; PCSrcE = t.pc; ImemReadyF = t.im; DmemBusyM = t.busy;
  endtask

  // Called just after a rising edge; applies one cycle and compares mid-cycle.
  task automatic step(input string name, input vec_t t);
    exp_t got;
    drive(t);
    exp_q.push_back({t.s, t.e});
    @(negedge clk);
    got = exp_q.pop_front();
    check({name, " strobes"}, {25'd0, strobes()}, {25'd0, got.s});
    check({name, " BusErr"}, {31'd0, BusErr}, {31'd0, got.e});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] exp_sc, exp_fc;

    // Load-use, fetch waits, redirect into DROP and back
    tbl[0]  = idle(S_NONE, 1'b0);
    tbl[1]  = mk(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, S_LW,    1'b0);
    tbl[2]  = mk(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, S_NONE,  1'b0);
    tbl[3]  = mk(5'd0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, S_NONE,  1'b0);
    tbl[4]  = mk(5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, S_LW,    1'b0);
    tbl[5]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, S_FWAIT, 1'b0);
    tbl[6]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, S_REDIR, 1'b0);
    tbl[7]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, S_FWAIT, 1'b0);
    tbl[8]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, S_FWAIT, 1'b0);
    tbl[9]  = idle(S_FWAIT, 1'b0);
    tbl[10] = idle(S_NONE, 1'b0);
    // Busy with a held branch, acted on when busy drops
    tbl[11] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, S_BUSY,  1'b0);
    tbl[12] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, S_BUSY,  1'b0);
    tbl[13] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, S_BUSY,  1'b0);
    tbl[14] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, S_BUSY,  1'b0);
    tbl[15] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, S_REDIR, 1'b0);
    tbl[16] = idle(S_NONE, 1'b0);
    // Busy arriving during DROP: drop remembered across the wait
    tbl[17] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, S_REDIR, 1'b0);
    tbl[18] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, S_BUSY,  1'b0);
    tbl[19] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, S_BUSY,  1'b0);
    tbl[20] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, S_FWAIT, 1'b0);
    tbl[21] = idle(S_FWAIT, 1'b0);
    tbl[22] = idle(S_NONE, 1'b0);
    // Load-use and branch while in DROP
    tbl[23] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, S_REDIR, 1'b0);
    tbl[24] = mk(5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, S_LW,    1'b0);
    tbl[25] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, S_DRPBR, 1'b0);
    tbl[26] = idle(S_FWAIT, 1'b0);
    tbl[27] = idle(S_NONE, 1'b0);

    rst = 1'b1;
    drive(idle(S_NONE, 1'b0));
    #2;
    check("reset strobes", {25'd0, strobes()}, 32'd0);
    check("reset BusErr", {31'd0, BusErr}, 32'd0);
    check("reset StallCnt", StallCnt, 32'd0);
    check("reset FlushCnt", FlushCnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 28; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Watchdog: error from the 8th busy cycle, sticky afterwards
    for (int i = 1; i <= 10; i++)
      step($sformatf("busy%0d", i),
           mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, S_BUSY, (i >= MT) ? 1'b1 : 1'b0));
    step("after busy 0", idle(S_NONE, 1'b1));
    step("after busy 1", idle(S_NONE, 1'b1));

    // Asynchronous reset while in DROP
    step("enter drop", mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, S_REDIR, 1'b1));
    drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, S_FWAIT, 1'b1));
    #1;
    check("in drop strobes", {25'd0, strobes()}, {25'd0, S_FWAIT});
    #1 rst = 1'b1;
    #1;
    check("rst drop strobes", {25'd0, strobes()}, 32'd0);
    check("rst drop BusErr", {31'd0, BusErr}, 32'd0);
    check("rst drop StallCnt", StallCnt, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("post rst drop", idle(S_NONE, 1'b0));

    // Asynchronous reset while in MEM_WAIT
    step("enter wait", mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, S_BUSY, 1'b0));
    #1;
    check("in wait strobes", {25'd0, strobes()}, {25'd0, S_BUSY});
    #1 rst = 1'b1;
    #1;
    check("rst wait strobes", {25'd0, strobes()}, 32'd0);
    DmemBusyM = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("post rst wait", idle(S_NONE, 1'b0));

    // Performance counters
    rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      step($sformatf("perf lw%0d", i), mk(5'd9, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, S_LW, 1'b0));
    for (int i = 0; i < 2; i++)
      step($sformatf("perf fw%0d", i), mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, S_FWAIT, 1'b0));
    step("perf redir", mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, S_REDIR, 1'b0));
`ifdef HAZARD_PERF_EN
    exp_sc = 32'd5;
    exp_fc = 32'd3;
`else
    exp_sc = 32'd0;
    exp_fc = 32'd0;
`endif
    check("StallCnt", StallCnt, exp_sc);
    check("FlushCnt", FlushCnt, exp_fc);
    step("perf idle", idle(S_NONE, 1'b0));
    check("StallCnt hold", StallCnt, exp_sc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
